// File: rtl/gb_timer_if.sv
// Register bus between the IO address decoder and the DMG timer (0xff04-0xff07).
interface gb_timer_if;
  logic [1:0] adr;
  logic       sel_tim;
  logic       write;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (
    output adr,
    output sel_tim,
    output write,
    output din,
    input  dout
  );

  modport slave (
    input  adr,
    input  sel_tim,
    input  write,
    input  din,
    output dout
  );
endinterface

// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC, timer interrupt request and the APU divider tap.
// Define GB_TIMER_QUIRKS_EN for the delayed reload and DIV/TAC write glitch increments.
module gb_timer (
  input  logic      clk,
  input  logic      reset,
  gb_timer_if.slave bus,
  output logic      irq_tim,
  output logic      div_apu
);

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        inc_src_q, inc_src_d;
  logic        irq_q, irq_d;

  logic wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic inc_src, inc;

`ifdef GB_TIMER_QUIRKS_EN
  typedef enum logic [1:0] {StRun, StDelay, StReload} state_e;
  state_e     state_q, state_d;
  logic [1:0] dly_q, dly_d;
`endif

  function automatic logic tap_src(input logic [2:0] tac, input logic [15:0] cnt);
    logic b;
    case (tac[1:0])
      2'b00:   b = cnt[9];
      2'b01:   b = cnt[3];
      2'b10:   b = cnt[5];
      default: b = cnt[7];
    endcase
    return tac[2] & b;
  endfunction

  always_comb begin
    wr_en   = bus.sel_tim & bus.write;
    wr_div  = wr_en & (bus.adr == 2'd0);
    wr_tima = wr_en & (bus.adr == 2'd1);
    wr_tma  = wr_en & (bus.adr == 2'd2);
    wr_tac  = wr_en & (bus.adr == 2'd3);
  end

  always_comb begin
    div_cnt_d = wr_div ? 16'h0000 : div_cnt_q + 16'd1;
    tac_d     = wr_tac ? bus.din[2:0] : tac_q;
    inc_src   = tap_src(tac_q, div_cnt_q);
    inc       = inc_src_q & ~inc_src;
`ifdef GB_TIMER_QUIRKS_EN
    inc_src_d = inc_src;
`else
    // Re-seed the edge detector from the post-write value so writes cannot fake a fall.
    inc_src_d = (wr_div | wr_tac) ? tap_src(tac_d, div_cnt_d) : inc_src;
`endif
  end

`ifdef GB_TIMER_QUIRKS_EN
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    tima_d  = tima_q;
    tma_d   = wr_tma ? bus.din : tma_q;
    irq_d   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (wr_tima) begin
          tima_d = bus.din;
        end else if (inc) begin
          if (tima_q == 8'hff) begin
            tima_d  = 8'h00;
            dly_d   = 2'd3;
            state_d = StDelay;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      StDelay: begin
        dly_d = dly_q - 2'd1;
        if (wr_tima) begin
          tima_d  = bus.din;
          state_d = StRun;
        end else begin
          if (inc) tima_d = tima_q + 8'd1;
          if (dly_q == 2'd1) state_d = StReload;
        end
      end
      StReload: begin
        // A TMA write this cycle feeds TIMA directly; a TIMA write is dropped.
        tima_d  = wr_tma ? bus.din : tma_q;
        irq_d   = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end
`else
  always_comb begin
    tima_d = tima_q;
    tma_d  = wr_tma ? bus.din : tma_q;
    irq_d  = 1'b0;
    if (wr_tima) begin
      tima_d = bus.din;
    end else if (inc) begin
      if (tima_q == 8'hff) begin
        tima_d = tma_q;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 16'h0000;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      inc_src_q <= 1'b0;
      irq_q     <= 1'b0;
`ifdef GB_TIMER_QUIRKS_EN
      state_q   <= StRun;
      dly_q     <= 2'd0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      inc_src_q <= inc_src_d;
      irq_q     <= irq_d;
`ifdef GB_TIMER_QUIRKS_EN
      state_q   <= state_d;
      dly_q     <= dly_d;
`endif
    end
  end

  always_comb begin
    bus.dout = 8'hff;
    if (bus.sel_tim) begin
      case (bus.adr)
        2'd0:    bus.dout = div_cnt_q[15:8];
        2'd1:    bus.dout = tima_q;
        2'd2:    bus.dout = tma_q;
        default: bus.dout = {5'b11111, tac_q};
      endcase
    end
  end

  assign irq_tim = irq_q;
  assign div_apu = div_cnt_q[12];

endmodule
